// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encodings and baud divisors.
// Used by the buffered transmitter; the 8N1 receiver uses the same divisors.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int CLKS_115200 = 868;
    localparam int CLKS_921600 = 108;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO with a registered occupancy count.
// A push while full is dropped, even if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Push,
    input  logic [WIDTH-1:0]  i_Data,
    input  logic              i_Pop,
    output logic [WIDTH-1:0]  o_Data,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Full,
    output logic              o_Empty
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign o_Full  = (o_Count == FULL_CNT);
    assign o_Empty = (o_Count == '0);
    assign do_push = i_Push && !o_Full;
    assign do_pop  = i_Pop && !o_Empty;
    assign o_Data  = mem[rd_ptr];

    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                o_Count <= o_Count + 1'b1;
            end else if (do_pop && !do_push) begin
                o_Count <= o_Count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a back-to-back serialiser.
// Define UART_TX_PARITY_EN to insert a parity bit (odd when PARITY_ODD=1).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_921600,
    parameter int FIFO_ADDR_W  = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Tx_DV,
    input  logic [7:0]             i_Tx_Byte,
    output logic                   o_Tx_Ready,
    output logic [FIFO_ADDR_W:0]   o_Fifo_Count,
    output logic                   o_Tx_Serial,
    output logic                   o_Tx_Active,
    output logic                   o_Tx_Done
);

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_PRE  = 16'(CLKS_PER_BIT - 2);

    tx_state_t   state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  fifo_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    uart_tx_fifo #(
        .WIDTH  (8),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Push  (i_Tx_DV),
        .i_Data  (i_Tx_Byte),
        .i_Pop   (fifo_pop),
        .o_Data  (fifo_data),
        .o_Count (o_Fifo_Count),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty)
    );

    assign o_Tx_Ready = !fifo_full;
    assign bit_end    = (clk_cnt == CNT_LAST);
    // Pop from idle, or on the last stop cycle so frames run with no gap.
    assign fifo_pop   = !fifo_empty &&
                        ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            o_Tx_Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (fifo_pop) begin
                        shift       <= fifo_data;
                        state       <= START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_bit  <= (^fifo_data) ^ PARITY_ODD[0];
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        state       <= DATA;
                        o_Tx_Serial <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state       <= PARITY;
                            o_Tx_Serial <= parity_bit;
`else
                            state       <= STOP;
                            o_Tx_Serial <= 1'b1;
`endif
                        end else begin
                            o_Tx_Serial <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        state       <= STOP;
                        o_Tx_Serial <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        if (fifo_pop) begin
                            shift       <= fifo_data;
                            state       <= START;
                            o_Tx_Serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            parity_bit  <= (^fifo_data) ^ PARITY_ODD[0];
`endif
                        end else begin
                            state       <= IDLE;
                            o_Tx_Active <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                        // Registered pulse lands on the final stop cycle.
                        if (clk_cnt == CNT_PRE) o_Tx_Done <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx_buffered;

    localparam int CPB = 4;
    localparam int FAW = 4;
    localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * CPB;
    localparam logic [FL-1:0] DONE_EXP = {1'b1, {(FL-1){1'b0}}};
    localparam logic [FL-1:0] ACT_EXP  = {FL{1'b1}};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           dv = 1'b0;
    logic [7:0]     tx_byte = 8'h00;
    logic           o_Tx_Ready;
    logic [FAW:0]   o_Fifo_Count;
    logic           o_Tx_Serial;
    logic           o_Tx_Active;
    logic           o_Tx_Done;

    int n_total = 0;
    int n_pass  = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_ADDR_W  (FAW),
        .PARITY_ODD   (PODD)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Tx_DV      (dv),
        .i_Tx_Byte    (tx_byte),
        .o_Tx_Ready   (o_Tx_Ready),
        .o_Fifo_Count (o_Fifo_Count),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FL-1:0] frame_line(input logic [7:0] b);
        logic [FL-1:0] e;
        logic v;
        e = '0;
        for (int k = 0; k < FB; k++) begin
            if (k == 0) v = 1'b0;
            else if (k <= 8) v = b[k-1];
            else if (k == FB - 1) v = 1'b1;
            else v = (^b) ^ PODD;
            for (int c = 0; c < CPB; c++) e[k*CPB+c] = v;
        end
        return e;
    endfunction

    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        tx_byte = b;
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    task automatic capture_frame(input logic [7:0] b, input bit contig,
                                 input string tag,
                                 output logic [FB-1:0] mid);
        logic [FL-1:0] ol;
        logic [FL-1:0] od;
        logic [FL-1:0] oa;
        logic [FL-1:0] el;
        int w;
        w = 0;
        mid = '0;
        el = frame_line(b);
        @(negedge clk);
        if (!contig) begin
            while (o_Tx_Serial !== 1'b0 && w < 400) begin
                @(negedge clk);
                w++;
            end
        end
        n_total++;
        if (w >= 400) begin
            $display("FAIL %s start: waited %0d cycles, limit 400", tag, w);
            return;
        end
        n_pass++;
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            ol[i] = o_Tx_Serial;
            od[i] = o_Tx_Done;
            oa[i] = o_Tx_Active;
            if (i % CPB == CPB / 2) mid[i/CPB] = o_Tx_Serial;
        end
        n_total++;
        if (ol !== el) $display("FAIL %s line: got %h want %h", tag, ol, el);
        else n_pass++;
        n_total++;
        if (od !== DONE_EXP) $display("FAIL %s done: got %h want %h", tag, od, DONE_EXP);
        else n_pass++;
        n_total++;
        if (oa !== ACT_EXP) $display("FAIL %s active: got %h want %h", tag, oa, ACT_EXP);
        else n_pass++;
    endtask

    task automatic test_reset();
        int bad_s, bad_r, bad_c, bad_a;
        bad_s = 0; bad_r = 0; bad_c = 0; bad_a = 0;
        @(negedge clk);
        n_total++;
        if ({o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done} !== 4'b1100)
            $display("FAIL reset_held: got %b want 1100",
                     {o_Tx_Serial, o_Tx_Ready, o_Tx_Active, o_Tx_Done});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_Tx_Serial !== 1'b1) bad_s++;
            if (o_Tx_Ready !== 1'b1) bad_r++;
            if (o_Fifo_Count !== '0) bad_c++;
            if (o_Tx_Active !== 1'b0) bad_a++;
        end
        n_total++;
        if (bad_s != 0) $display("FAIL idle_serial: %0d bad cycles, want 0", bad_s);
        else n_pass++;
        n_total++;
        if (bad_r != 0) $display("FAIL idle_ready: %0d bad cycles, want 0", bad_r);
        else n_pass++;
        n_total++;
        if (bad_c != 0) $display("FAIL idle_count: %0d bad cycles, want 0", bad_c);
        else n_pass++;
        n_total++;
        if (bad_a != 0) $display("FAIL idle_active: %0d bad cycles, want 0", bad_a);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [FB-1:0] mid;
        logic [FB-1:0] want;
`ifdef UART_TX_PARITY_EN
        want = 11'b10101001010;
`else
        want = 10'b1101001010;
`endif
        send(8'hA5);
        @(negedge clk);
        n_total++;
        if ({o_Tx_Serial, o_Tx_Active, o_Fifo_Count} !== {2'b10, 5'd1})
            $display("FAIL single_latency: got ser=%b act=%b cnt=%0d want 1 0 1",
                     o_Tx_Serial, o_Tx_Active, o_Fifo_Count);
        else n_pass++;
        capture_frame(8'hA5, 1'b1, "single", mid);
        n_total++;
        if (mid !== want) $display("FAIL single_bits: got %b want %b", mid, want);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count} !== {3'b100, 5'd0})
            $display("FAIL single_idle: got ser=%b act=%b done=%b cnt=%0d want 1 0 0 0",
                     o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] mid;
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    dv = 1'b1;
                    tx_byte = bytes[i];
                    @(posedge clk);
                    #1;
                end
                dv = 1'b0;
                tx_byte = 8'hEE;
            end
            begin
                capture_frame(8'h00, 1'b0, "b2b_0", mid);
                capture_frame(8'hFF, 1'b1, "b2b_1", mid);
                capture_frame(8'h55, 1'b1, "b2b_2", mid);
            end
        join
        @(negedge clk);
        n_total++;
        if ({o_Tx_Serial, o_Tx_Active} !== 2'b10)
            $display("FAIL b2b_idle: got ser=%b act=%b want 1 0", o_Tx_Serial, o_Tx_Active);
        else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [FB-1:0] mid;
        int lows, dones;
        lows = 0; dones = 0;
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    dv = 1'b1;
                    tx_byte = 8'(i);
                    @(posedge clk);
                    #1;
                end
                dv = 1'b0;
                tx_byte = 8'hC3;
                @(negedge clk);
                n_total++;
                if (o_Fifo_Count !== 5'd16)
                    $display("FAIL full_count: got %0d want 16", o_Fifo_Count);
                else n_pass++;
                n_total++;
                if (o_Tx_Ready !== 1'b0)
                    $display("FAIL full_ready: got %b want 0", o_Tx_Ready);
                else n_pass++;
            end
            begin
                for (int f = 0; f < 17; f++) begin
                    capture_frame(8'(f), f != 0, $sformatf("full_f%0d", f), mid);
                end
            end
        join
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            if (o_Tx_Serial !== 1'b1) lows++;
            if (o_Tx_Done !== 1'b0) dones++;
        end
        n_total++;
        if (lows != 0 || dones != 0)
            $display("FAIL full_no_extra: lows=%0d dones=%0d want 0 0", lows, dones);
        else n_pass++;
        n_total++;
        if ({o_Fifo_Count, o_Tx_Ready} !== {5'd0, 1'b1})
            $display("FAIL full_drain: got cnt=%0d rdy=%b want 0 1", o_Fifo_Count, o_Tx_Ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [FB-1:0] mid;
        int lows, dones;
        lows = 0; dones = 0;
        send(8'h3C);
        repeat (18) @(posedge clk);
        #1;
        n_total++;
        if (o_Tx_Active !== 1'b1)
            $display("FAIL midrst_pre: active got %b want 1", o_Tx_Active);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count} !== {3'b100, 5'd0})
            $display("FAIL midrst_post: got ser=%b act=%b done=%b cnt=%0d want 1 0 0 0",
                     o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_Tx_Serial !== 1'b1) lows++;
            if (o_Tx_Done !== 1'b0) dones++;
        end
        n_total++;
        if (lows != 0 || dones != 0)
            $display("FAIL midrst_quiet: lows=%0d dones=%0d want 0 0", lows, dones);
        else n_pass++;
        send(8'h81);
        @(negedge clk);
        capture_frame(8'h81, 1'b1, "midrst_81", mid);
        n_total++;
        if (mid[8:1] !== 8'h81) $display("FAIL midrst_data: got %h want 81", mid[8:1]);
        else n_pass++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [FB-1:0] mid;
        send(8'h07);
        @(negedge clk);
        capture_frame(8'h07, 1'b1, "parity", mid);
        n_total++;
        if (mid[FB-2] !== (1'b1 ^ PODD))
            $display("FAIL parity_bit: got %b want %b", mid[FB-2], 1'b1 ^ PODD);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
